gated_frame_packer: RTL and testbench

GATED_FRAME_PACKER -- requirements
Module: gated_frame_packer

---
 rtl/gated_frame_packer.sv | 165 ++++++++++++++++
 tb/tb_gated_frame_packer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gated_frame_packer.sv
// Gated ADC frame packer: buffers sample sets in a FIFO while the gate is open and
// streams each set as 0xA5 + MSB-first channel bytes. FRAME_CHECKSUM_EN appends an XOR byte.
module gated_frame_packer #(
  parameter int NB_CHANNELS = 2,
  parameter int DATA_SIZE   = 14,
  parameter int DEPTH       = 16
) (
  input  logic                             i_clock,
  input  logic                             i_reset,
  input  logic                             i_gate,
  input  logic                             i_adc_init,
  input  logic [NB_CHANNELS*DATA_SIZE-1:0] i_data,
  input  logic                             i_tx_ready,
  output logic [7:0]                       o_tx_data,
  output logic                             o_tx_send,
  output logic                             o_overflow,
  output logic                             o_busy
);
  localparam int SET_W = NB_CHANNELS * DATA_SIZE;
  localparam int AW    = $clog2(DEPTH);
  localparam int BPS   = (DATA_SIZE + 7) / 8;
  localparam int SW    = BPS * 8;
  localparam int PL_W  = NB_CHANNELS * SW;
`ifdef FRAME_CHECKSUM_EN
  localparam int NB_BYTES = NB_CHANNELS * BPS + 1;
`else
  localparam int NB_BYTES = NB_CHANNELS * BPS;
`endif
  localparam int CW = $clog2(NB_BYTES + 1);

  localparam logic [7:0]    SYNC      = 8'hA5;
  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [CW-1:0] LEFT_ONE  = 1;
  localparam logic [CW-1:0] LEFT_INIT = CW'(NB_BYTES);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD      = 3'd1;
  localparam logic [2:0] SEND      = 3'd2;
  localparam logic [2:0] WAIT_BUSY = 3'd3;
  localparam logic [2:0] WAIT_DONE = 3'd4;
  localparam logic [2:0] NEXT      = 3'd5;

  logic [SET_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             fifo_empty, fifo_full, push_req, push, pop, drop;
  logic             gate_q, gate_rise, overflow_q;
  logic [2:0]       state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_send_q, tx_send_d;
  logic [PL_W-1:0]  sr_q, sr_d, payload;
  logic [CW-1:0]    left_q, left_d;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]       csum_q, csum_d;
`endif

  // The extra pointer bit tells a full FIFO (MSBs differ) from an empty one.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_req   = i_gate & i_adc_init;
  assign pop        = (state_q == LOAD);
  assign push       = push_req & (~fifo_full | pop);
  assign drop       = push_req & fifo_full & ~pop;
  assign gate_rise  = i_gate & ~gate_q;

  // NOTE: sample storage has no reset; only the pointers define validity.
  always_ff @(posedge i_clock) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= i_data;
  end

  always_comb begin
    payload = '0;
    for (int c = 0; c < NB_CHANNELS; c++) begin
      payload[PL_W - (c + 1) * SW +: SW] = SW'(mem[rd_ptr_q[AW-1:0]][c * DATA_SIZE +: DATA_SIZE]);
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    tx_send_d = 1'b0;
    tx_data_d = tx_data_q;
    sr_d      = sr_q;
    left_d    = left_q;
`ifdef FRAME_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        sr_d      = payload;
        tx_data_d = SYNC;
        left_d    = LEFT_INIT;
`ifdef FRAME_CHECKSUM_EN
        csum_d    = '0;
`endif
        state_d   = SEND;
      end
      SEND: if (i_tx_ready) begin
        tx_send_d = 1'b1;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: if (!i_tx_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (i_tx_ready) state_d = NEXT;
      NEXT: begin
        if (left_q == '0) begin
          state_d = fifo_empty ? IDLE : LOAD;
        end else begin
          left_d  = left_q - LEFT_ONE;
          state_d = SEND;
`ifdef FRAME_CHECKSUM_EN
          if (left_q == LEFT_ONE) begin
            tx_data_d = csum_q;
          end else begin
            tx_data_d = sr_q[PL_W-1 -: 8];
            csum_d    = csum_q ^ sr_q[PL_W-1 -: 8];
            sr_d      = sr_q << 8;
          end
`else
          tx_data_d = sr_q[PL_W-1 -: 8];
          sr_d      = sr_q << 8;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      gate_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      tx_send_q  <= 1'b0;
      sr_q       <= '0;
      left_q     <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      gate_q     <= i_gate;
      overflow_q <= (gate_rise ? 1'b0 : overflow_q) | drop;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
      sr_q       <= sr_d;
      left_q     <= left_d;
`ifdef FRAME_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign o_tx_data  = tx_data_q;
  assign o_tx_send  = tx_send_q;
  assign o_overflow = overflow_q;
  assign o_busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_gated_frame_packer.sv
// Directed bench for gated_frame_packer (2 channels x 14 bits, FIFO depth 4)
// with a simple byte-transmitter model that goes busy for a few cycles per byte.
module tb_gated_frame_packer;
  logic        clk = 1'b0;
  logic        rst;
  logic        gate;
  logic        adc_init;
  logic [27:0] data;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic       tx_auto     = 1'b1;
  logic       tx_manual   = 1'b1;
  logic       model_ready = 1'b1;
  int         busy_cnt    = 0;
  int         pulse_err   = 0;
  logic       send_prev   = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  gated_frame_packer #(.NB_CHANNELS(2), .DATA_SIZE(14), .DEPTH(4)) dut (
    .i_clock   (clk),
    .i_reset   (rst),
    .i_gate    (gate),
    .i_adc_init(adc_init),
    .i_data    (data),
    .i_tx_ready(tx_ready),
    .o_tx_data (tx_data),
    .o_tx_send (tx_send),
    .o_overflow(overflow),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  assign tx_ready = tx_auto ? model_ready : tx_manual;

  // Transmitter model: records every requested byte, then stays busy 3 cycles.
  always @(negedge clk) begin
    if (send_prev && tx_send) pulse_err++;
    send_prev = tx_send;
    if (tx_send) rx_q.push_back(tx_data);
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) model_ready = 1'b1;
    end else if (tx_send) begin
      model_ready = 1'b0;
      busy_cnt    = 3;
    end
  end

  function automatic void push_frame(input logic [13:0] c0, input logic [13:0] c1);
    logic [7:0] b [4];
    b[0] = {2'b00, c0[13:8]};
    b[1] = c0[7:0];
    b[2] = {2'b00, c1[13:8]};
    b[3] = c1[7:0];
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(b[i]);
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(b[0] ^ b[1] ^ b[2] ^ b[3]);
`endif
  endfunction

  task automatic drive_sets(input int n, input logic [13:0] b0, input logic [13:0] b1);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      gate = 1'b1;
      data = {b1 + 14'(k), b0 + 14'(k)};
    end
    @(negedge clk);
    gate = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; gate = 1'b0; adc_init = 1'b1; data = '0;
    tx_auto = 1'b1; tx_manual = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++; if (tx_send !== 1'b0) begin failures++; $display("FAIL reset_send got=%b want=0", tx_send); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", tx_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b want=0", overflow); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_send !== 1'b0) begin
      failures++; $display("FAIL post_reset_idle busy=%b send=%b want 0/0", busy, tx_send);
    end
  endtask

  task automatic test_single_frame();
    logic [7:0] want [6];
    int         n;
    bit         ok;
    want = '{8'hA5, 8'h1A, 8'hBC, 8'h01, 8'h23, 8'h84};
`ifdef FRAME_CHECKSUM_EN
    n = 6;
`else
    n = 5;
`endif
    rx_q.delete();
    drive_sets(1, 14'h1ABC, 14'h0123);
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout busy still high"); end
    checks++; if (rx_q.size() != n) begin failures++; $display("FAIL single_len got=%0d want=%0d", rx_q.size(), n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== want[i]) begin
        failures++; $display("FAIL single_byte%0d got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, want[i]);
      end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    rx_q.delete(); exp_q.delete();
    tx_auto = 1'b0; tx_manual = 1'b0;
    drive_sets(10, 14'h0010, 14'h2000);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b want=1", overflow); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ovf_busy got=%b want=1", busy); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL ovf_no_send got=%0d bytes want=0", rx_q.size()); end
    repeat (5) @(negedge clk);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
    // One set sits in the frame register, four in the FIFO: sets 0..4 survive.
    for (int k = 0; k < 5; k++) push_frame(14'h0010 + 14'(k), 14'h2000 + 14'(k));
    tx_auto = 1'b1;
    wait_idle(2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_drain_timeout busy still high"); end
    checks++; if (rx_q.size() != exp_q.size()) begin
      failures++; $display("FAIL ovf_len got=%0d want=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL ovf_byte%0d got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_hold_after_drain got=%b want=1", overflow); end
    @(negedge clk);
    gate = 1'b1; data = {14'h0001, 14'h0002};
    @(negedge clk);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear_on_gate got=%b want=0", overflow); end
    gate = 1'b0;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_tail_timeout busy still high"); end
    rx_q.delete();
  endtask

  task automatic test_adc_inhibit();
    int saw_busy = 0;
    int saw_send = 0;
    rx_q.delete();
    adc_init = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      gate = (k < 5);
      data = {14'h1111, 14'h2222};
      if (busy) saw_busy++;
      if (tx_send) saw_send++;
    end
    gate = 1'b0;
    adc_init = 1'b1;
    checks++; if (saw_busy != 0) begin failures++; $display("FAIL inhibit_busy cycles=%0d want=0", saw_busy); end
    checks++; if (saw_send != 0) begin failures++; $display("FAIL inhibit_send pulses=%0d want=0", saw_send); end
    checks++; if (rx_q.size() != 0) begin failures++; $display("FAIL inhibit_bytes got=%0d want=0", rx_q.size()); end
  endtask

  task automatic test_stall();
    bit         found = 1'b0;
    bit         ok;
    logic [7:0] d0;
    int         extra = 0;
    int         chg   = 0;
    rx_q.delete(); exp_q.delete();
    tx_auto = 1'b0; tx_manual = 1'b1;
    push_frame(14'h3FFF, 14'h0081);
    drive_sets(1, 14'h3FFF, 14'h0081);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_send) begin found = 1'b1; break; end
    end
    tx_manual = 1'b0;
    d0 = tx_data;
    checks++; if (!found) begin failures++; $display("FAIL stall_first_send no pulse seen"); end
    checks++; if (d0 !== 8'hA5) begin failures++; $display("FAIL stall_first_byte got=%h want=a5", d0); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_send) extra++;
      if (tx_data !== d0) chg++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL stall_extra_send pulses=%0d want=0", extra); end
    checks++; if (chg != 0) begin failures++; $display("FAIL stall_data_change cycles=%0d want=0", chg); end
    tx_auto = 1'b1;
    wait_idle(300, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout busy still high"); end
    checks++; if (rx_q.size() != exp_q.size()) begin
      failures++; $display("FAIL stall_len got=%0d want=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL stall_byte%0d got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int cnt   = 0;
    int after = 0;
    int busy_after = 0;
    rx_q.delete();
    tx_auto = 1'b1;
    drive_sets(1, 14'h0555, 14'h1AAA);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (tx_send) cnt++;
      if (cnt == 3) break;
    end
    checks++; if (cnt != 3) begin failures++; $display("FAIL midrst_third_byte pulses=%0d want=3", cnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (tx_send !== 1'b0) begin failures++; $display("FAIL midrst_send got=%b want=0", tx_send); end
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL midrst_data got=%h want=00", tx_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL midrst_ovf got=%b want=0", overflow); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx_send) after++;
      if (busy) busy_after++;
    end
    checks++; if (after != 0) begin failures++; $display("FAIL midrst_resumed pulses=%0d want=0", after); end
    checks++; if (busy_after != 0) begin failures++; $display("FAIL midrst_busy_after cycles=%0d want=0", busy_after); end
    rx_q.delete();
  endtask

  task automatic test_back_to_back();
    bit fell = 1'b0;
    int late = 0;
    rx_q.delete(); exp_q.delete();
    tx_auto = 1'b1;
    for (int k = 0; k < 3; k++) push_frame(14'h3A00 + 14'(k), 14'h0055 + 14'(k));
    drive_sets(3, 14'h3A00, 14'h0055);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!busy) begin fell = 1'b1; break; end
    end
    checks++; if (!fell) begin failures++; $display("FAIL b2b_timeout busy still high"); end
    checks++; if (rx_q.size() != exp_q.size()) begin
      failures++; $display("FAIL b2b_len_at_idle got=%0d want=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL b2b_byte%0d got=%h want=%h", i, (i < rx_q.size()) ? rx_q[i] : 8'hxx, exp_q[i]);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || tx_send) late++;
    end
    checks++; if (late != 0) begin failures++; $display("FAIL b2b_quiet cycles=%0d want=0", late); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overflow();
    test_adc_inhibit();
    test_stall();
    test_reset_mid_frame();
    test_back_to_back();
    checks++; if (pulse_err != 0) begin failures++; $display("FAIL send_pulse_width long_pulses=%0d want=0", pulse_err); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
